// File: rtl/reg_bank_arbiter_if.sv
// Shared bus between the two requesters, the arbiter and the general register bank.
// Carries request/ack handshakes of both ports plus the bank strobe/address/data bus.
// slave = arbiter view, master = requesters-plus-bank view.
interface reg_bank_arbiter_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  req0;
   logic                  req1;
   logic                  we0;
   logic                  we1;
   logic [DATA_WIDTH-1:0] addr0;
   logic [DATA_WIDTH-1:0] addr1;
   logic [DATA_WIDTH-1:0] wdata0;
   logic [DATA_WIDTH-1:0] wdata1;
   logic                  ack0;
   logic                  ack1;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  busy;
   logic                  read_flag;
   logic                  write_flag;
   logic [DATA_WIDTH-1:0] amba_addr;
   logic [DATA_WIDTH-1:0] data_in;
   logic [DATA_WIDTH-1:0] bank_data_out;

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, bank_data_out,
      output ack0, ack1, rdata, busy, read_flag, write_flag, amba_addr, data_in
   );

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, bank_data_out,
      input  ack0, ack1, rdata, busy, read_flag, write_flag, amba_addr, data_in
   );
endinterface

// File: rtl/reg_bank_arbiter.sv
// Two-port arbiter/sequencer for the general register bank: IDLE -> ACCESS -> WAIT -> ACK.
// Latency: grant edge to ack = 3 cycles; one transaction per 4 cycles at most.
// Backpressure: requests are levels held until ack; only sampled in IDLE. Build option REG_ARB_FIXED_PRIO_EN selects fixed priority (port 0 wins ties) instead of round-robin.
module reg_bank_arbiter #(
   parameter int DATA_WIDTH = 8
) (
   input  logic               SYS_CLK,
   input  logic               rst,
   reg_bank_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_WAIT   = 2'd2,
      S_ACK    = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic                  we_q, we_d;
   logic [DATA_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  gnt_q, gnt_d;      // 0 = port 0 granted, 1 = port 1
   logic                  win;

`ifndef REG_ARB_FIXED_PRIO_EN
   logic                  last_grant_q, last_grant_d;
`endif

   logic                  ack0_q, ack0_d;
   logic                  ack1_q, ack1_d;
   logic                  busy_q, busy_d;
   logic                  rd_flag_q, rd_flag_d;
   logic                  wr_flag_q, wr_flag_d;
   logic [DATA_WIDTH-1:0] amba_addr_q, amba_addr_d;
   logic [DATA_WIDTH-1:0] data_in_q, data_in_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

   // Arbitration: a lone request wins outright; a tie goes by priority policy.
   always_comb begin
`ifdef REG_ARB_FIXED_PRIO_EN
      win = !bus.req0;
`else
      win = (bus.req0 && bus.req1) ? !last_grant_q : bus.req1;
`endif
   end

   // Next state and transaction latch; requests are only looked at in IDLE.
   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      gnt_d   = gnt_q;
`ifndef REG_ARB_FIXED_PRIO_EN
      last_grant_d = last_grant_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.req0 || bus.req1) begin
               state_d = S_ACCESS;
               gnt_d   = win;
               we_d    = win ? bus.we1    : bus.we0;
               addr_d  = win ? bus.addr1  : bus.addr0;
               wdata_d = win ? bus.wdata1 : bus.wdata0;
`ifndef REG_ARB_FIXED_PRIO_EN
               last_grant_d = win;
`endif
            end
         end
         S_ACCESS: state_d = S_WAIT;
         S_WAIT:   state_d = S_ACK;
         S_ACK:    state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Outputs are computed from the upcoming state so that every port is a flop.
   always_comb begin
      busy_d      = (state_d != S_IDLE);
      rd_flag_d   = (state_d == S_ACCESS) && !we_d;
      wr_flag_d   = (state_d == S_ACCESS) &&  we_d;
      amba_addr_d = (state_d == S_ACCESS) ? addr_d  : amba_addr_q;
      data_in_d   = (state_d == S_ACCESS) ? wdata_d : data_in_q;
      ack0_d      = (state_d == S_ACK) && !gnt_d;
      ack1_d      = (state_d == S_ACK) &&  gnt_d;
      // Bank data is valid during WAIT; capture it on the edge that ends WAIT.
      rdata_d     = (state_q == S_WAIT && !we_q) ? bus.bank_data_out : rdata_q;
   end

   // State register and latched transaction fields.
   always_ff @(posedge SYS_CLK or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         gnt_q   <= 1'b0;
`ifndef REG_ARB_FIXED_PRIO_EN
         last_grant_q <= 1'b1;
`endif
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         gnt_q   <= gnt_d;
`ifndef REG_ARB_FIXED_PRIO_EN
         last_grant_q <= last_grant_d;
`endif
      end
   end

   // Output registers.
   always_ff @(posedge SYS_CLK or posedge rst) begin
      if (rst) begin
         ack0_q      <= 1'b0;
         ack1_q      <= 1'b0;
         busy_q      <= 1'b0;
         rd_flag_q   <= 1'b0;
         wr_flag_q   <= 1'b0;
         amba_addr_q <= '0;
         data_in_q   <= '0;
         rdata_q     <= '0;
      end else begin
         ack0_q      <= ack0_d;
         ack1_q      <= ack1_d;
         busy_q      <= busy_d;
         rd_flag_q   <= rd_flag_d;
         wr_flag_q   <= wr_flag_d;
         amba_addr_q <= amba_addr_d;
         data_in_q   <= data_in_d;
         rdata_q     <= rdata_d;
      end
   end

   assign bus.ack0       = ack0_q;
   assign bus.ack1       = ack1_q;
   assign bus.busy       = busy_q;
   assign bus.read_flag  = rd_flag_q;
   assign bus.write_flag = wr_flag_q;
   assign bus.amba_addr  = amba_addr_q;
   assign bus.data_in    = data_in_q;
   assign bus.rdata      = rdata_q;

endmodule

// File: doc/reg_bank_arbiter.md
# reg_bank_arbiter

Two-port arbiter and access sequencer for the general-purpose register bank on the AMBA-side bus. Two requesters (port 0, port 1) issue single read or write transactions. The block grants one at a time, drives the shared bank strobes, address and write data, and returns read data with a one-cycle acknowledge. It sits between the bus-facing masters and the bank of general registers, which share one strobe/address/data bus.

## Interface
Parameters:
- DATA_WIDTH, 8, width of address, write data and read data.

Ports:
- SYS_CLK  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- req0 / req1  in  1  transaction request from port 0 / port 1; level, held until matching ack.
- we0 / we1  in  1  1 = write, 0 = read; sampled at grant.
- addr0 / addr1  in  DATA_WIDTH  target register address; sampled at grant.
- wdata0 / wdata1  in  DATA_WIDTH  write data; sampled at grant.
- ack0 / ack1  out  1  one-cycle pulse: transaction of that port completed.
- rdata  out  DATA_WIDTH  read data. Valid while ack0 or ack1 is high after a read. Holds its value otherwise.
- busy  out  1  high in any state other than IDLE.
- read_flag  out  1  bank read strobe.
- write_flag  out  1  bank write strobe.
- amba_addr  out  DATA_WIDTH  bank address bus.
- data_in  out  DATA_WIDTH  bank write data.
- bank_data_out  in  DATA_WIDTH  bank read data. The bank registers it on the SYS_CLK edge that ends a read_flag cycle.

## Operation
- FSM states: IDLE, ACCESS, WAIT, ACK. Encoding is free.
- **IDLE:**
  - If any request is pending, arbitrate, latch the winner's we/addr/wdata into internal registers, store the winner id, and go to ACCESS.
  - Otherwise stay in IDLE.
- **ACCESS**, exactly 1 cycle:
  - amba_addr and data_in are driven from the latched values.
  - read_flag = !we_latched and write_flag = we_latched; exactly one strobe is high.
  - Next state is WAIT.
- **WAIT**, 1 cycle:
  - Both strobes are low; amba_addr holds its value.
  - rdata is loaded from bank_data_out at the end of WAIT, for reads only.
  - Next state is ACK.
- **ACK**, 1 cycle:
  - ack of the granted port is high; the other ack stays low.
  - Next state is IDLE.
- Arbitration is round-robin with a 1-bit last_grant register:
  - If only one request is present, that port wins.
  - If both are present, the port not equal to last_grant wins.
  - last_grant updates at every grant.
- Requests are sampled only in IDLE. Dropping req after grant does not cancel the transaction; ack still pulses.
- A requester holding req high in the cycle after its ack is treated as a new request.

## Timing
- Reset values:
  - state = IDLE; last_grant = 1, so port 0 wins the first tie.
  - ack0 = ack1 = 0; busy = 0; read_flag = write_flag = 0.
  - amba_addr = data_in = rdata = 0.
- Latency:
  - Request seen at edge N → ACCESS during cycle N+1 → WAIT N+2 → ACK N+3.
  - ack high for exactly one cycle, 3 cycles after grant.
- Maximum throughput is one transaction per 4 cycles. Back-to-back grants alternate ports when both requests are held.
- All outputs are registered; no combinational path from request inputs to any output.
- A write completes in the bank at the end of ACCESS. A read of the same address in the next transaction returns the new value.
- Reset asserted mid-transaction:
  - Immediate return to IDLE; all outputs take their reset values.
  - No ack is issued for the aborted transaction.
  - A write whose ACCESS cycle was cut is not guaranteed to have completed.

## Configuration
- Macro REG_ARB_FIXED_PRIO_EN:
  - **Defined:** fixed priority, port 0 always wins a tie. last_grant is not implemented.
  - **Undefined (default):** round-robin as described in Operation.
  - All other behaviour and timing are identical in both builds.

## Test plan
- After reset, req0 write addr=0x05 wdata=0xA5 → write_flag high 1 cycle with amba_addr=0x05, data_in=0xA5; ack0 3 cycles after grant; busy high for ACCESS–ACK.
- Then req1 read addr=0x05 → read_flag high 1 cycle; ack1 with rdata=0xA5; ack0 stays 0.
- req0 and req1 raised in the same cycle from reset, both held → grants port0, port1, port0, port1 (round-robin). With REG_ARB_FIXED_PRIO_EN defined: port0 every time while req0 is held.
- req0 read addr=0x10 pulsed for one cycle only → transaction still completes; ack0 pulses once; no second transaction.
- rst asserted during the WAIT state of a read → all outputs 0 next cycle, no ack. After release, a fresh req1 is served normally with 3-cycle grant-to-ack latency.
